// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the write-arbiter state encoding.
package axi4lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        XFER = ST_XFER,
        RESP = ST_RESP,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after last+1 (mod N).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_grant_valid,
    output logic [IW-1:0] o_grant_idx,
    output logic [N-1:0]  o_grant_onehot
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(i_last) + k) % N);
            if (!o_grant_valid && i_req[w_cand]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_cand;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign o_grant_onehot[gi] = o_grant_valid && (o_grant_idx == IW'(gi));
    end

endmodule

// File: rtl/axi4lite_write_arbiter.sv
// Serialises single-beat writes from N requesters onto one AXI4-Lite write port,
// granting round-robin and returning BRESP to the issuing requester.
module axi4lite_write_arbiter
    import axi4lite_pkg::*;
#(
    parameter int         N          = 4,
    parameter logic [2:0] AWPROT_VAL = 3'b000
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [N-1:0]    req,
    input  logic [N*32-1:0] req_addr,
    input  logic [N*32-1:0] req_data,
    input  logic [N*4-1:0]  req_strb,
    output logic [N-1:0]    done,
    output logic [1:0]      done_resp,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     awaddr,
    output logic [2:0]      awprot,
    output logic            wvalid,
    input  logic            wready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp
);

    localparam int IW = $clog2(N);

    state_t        r_state, r_state_next;
    logic [IW-1:0] r_last, r_last_next;
    logic          r_awvalid, r_awvalid_next;
    logic          r_wvalid, r_wvalid_next;
    logic          r_bready, r_bready_next;
    logic [31:0]   r_awaddr, r_awaddr_next;
    logic [31:0]   r_wdata, r_wdata_next;
    logic [3:0]    r_wstrb, r_wstrb_next;
    logic [N-1:0]  r_done, r_done_next;
    logic [1:0]    r_done_resp, r_done_resp_next;

    logic          w_gnt_valid;
    logic [IW-1:0] w_gnt_idx;
    logic [N-1:0]  w_gnt_onehot;
    logic [N-1:0]  w_last_onehot;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .i_req          (req),
        .i_last         (r_last),
        .o_grant_valid  (w_gnt_valid),
        .o_grant_idx    (w_gnt_idx),
        .o_grant_onehot (w_gnt_onehot)
    );

    // r_last doubles as the index of the in-flight grant once past IDLE.
    for (genvar gi = 0; gi < N; gi++) begin : g_last_onehot
        assign w_last_onehot[gi] = (r_last == IW'(gi));
    end

    always_comb begin
        r_state_next     = r_state;
        r_last_next      = r_last;
        r_awvalid_next   = r_awvalid;
        r_wvalid_next    = r_wvalid;
        r_bready_next    = r_bready;
        r_awaddr_next    = r_awaddr;
        r_wdata_next     = r_wdata;
        r_wstrb_next     = r_wstrb;
        r_done_next      = r_done;
        r_done_resp_next = r_done_resp;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    r_awaddr_next  = req_addr[int'(w_gnt_idx)*32 +: 32];
                    r_wdata_next   = req_data[int'(w_gnt_idx)*32 +: 32];
                    r_wstrb_next   = req_strb[int'(w_gnt_idx)*4 +: 4];
                    r_awvalid_next = 1'b1;
                    r_wvalid_next  = 1'b1;
                    r_last_next    = w_gnt_idx;
                    r_state_next   = XFER;
                end
            end
            XFER: begin
                // AW and W complete independently; leave once both are gone.
                r_awvalid_next = r_awvalid && !awready;
                r_wvalid_next  = r_wvalid && !wready;
                if (!r_awvalid_next && !r_wvalid_next) begin
                    r_bready_next = 1'b1;
                    r_state_next  = RESP;
                end
            end
            RESP: begin
                if (bvalid) begin
                    r_done_next      = w_last_onehot;
                    r_done_resp_next = bresp;
                    r_bready_next    = 1'b0;
                    r_state_next     = DONE;
                end
            end
            DONE: begin
                r_done_next  = '0;
                r_state_next = IDLE;
            end
            default: r_state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_last      <= IW'(N - 1);
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_done      <= '0;
            r_done_resp <= OKAY;
        end else begin
            r_state     <= r_state_next;
            r_last      <= r_last_next;
            r_awvalid   <= r_awvalid_next;
            r_wvalid    <= r_wvalid_next;
            r_bready    <= r_bready_next;
            r_awaddr    <= r_awaddr_next;
            r_wdata     <= r_wdata_next;
            r_wstrb     <= r_wstrb_next;
            r_done      <= r_done_next;
            r_done_resp <= r_done_resp_next;
        end
    end

    assign done      = r_done;
    assign done_resp = r_done_resp;
    assign awvalid   = r_awvalid;
    assign awaddr    = r_awaddr;
    assign awprot    = AWPROT_VAL;
    assign wvalid    = r_wvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign bready    = r_bready;

endmodule

// File: tb/tb_axi4lite_write_arbiter.sv
// Directed and randomized bench for axi4lite_write_arbiter with a transaction-level
// round-robin reference model; inputs driven and outputs sampled on the falling edge.
module tb_axi4lite_write_arbiter;

    localparam int N = 4;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_data;
    logic [N*4-1:0]  req_strb;
    logic [N-1:0]    done;
    logic [1:0]      done_resp;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [31:0]     awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready = 1'b0;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            bvalid = 1'b0;
    logic            bready;
    logic [1:0]      bresp = 2'b00;

    logic [31:0] m_addr [N];
    logic [31:0] m_data [N];
    logic [3:0]  m_strb [N];
    int          m_last = N - 1;
    int          errors = 0;
    int          checks = 0;

    axi4lite_write_arbiter #(.N(N), .AWPROT_VAL(3'b000)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_strb  (req_strb),
        .done      (done),
        .done_resp (done_resp),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awprot    (awprot),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp)
    );

    always #5 aclk = ~aclk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        req_strb = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*32 +: 32] = m_addr[i];
            req_data[i*32 +: 32] = m_data[i];
            req_strb[i*4 +: 4]   = m_strb[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending requester after the previous grant, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic rand_payload(input int i);
        m_addr[i] = $urandom;
        m_data[i] = $urandom;
        m_strb[i] = 4'($urandom_range(0, 15));
    endtask

    // Entered at the falling edge of an IDLE cycle with req already driven (nonzero).
    task automatic run_txn(input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] resp, output int g);
        int hs;
        logic [N-1:0] exp_done;
        g  = rr_pick(req, m_last);
        hs = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int t = 0; t <= hs; t++) begin
            @(negedge aclk);
            check("awvalid", 32'(awvalid), 32'(t <= aw_dly));
            check("wvalid", 32'(wvalid), 32'(t <= w_dly));
            check("bready_xfer", 32'(bready), 32'd0);
            check("awaddr", awaddr, m_addr[g]);
            check("wdata", wdata, m_data[g]);
            check("wstrb", 32'(wstrb), 32'(m_strb[g]));
            awready = (t >= aw_dly);
            wready  = (t >= w_dly);
        end
        for (int s = 0; s <= b_dly; s++) begin
            @(negedge aclk);
            if (s == 0) begin
                check("awvalid_resp", 32'(awvalid), 32'd0);
                check("wvalid_resp", 32'(wvalid), 32'd0);
            end
            check("bready_resp", 32'(bready), 32'd1);
            check("done_early", 32'(done), 32'd0);
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = (s == b_dly);
            bresp   = (s == b_dly) ? resp : 2'($urandom_range(0, 3));
        end
        @(negedge aclk);
        exp_done    = '0;
        exp_done[g] = 1'b1;
        check("done", 32'(done), 32'(exp_done));
        check("done_resp", 32'(done_resp), 32'(resp));
        check("bready_done", 32'(bready), 32'd0);
        bvalid = 1'b0;
        req[g] = 1'b0;
        m_last = g;
        @(negedge aclk);
        check("done_cleared", 32'(done), 32'd0);
        $display("txn grant=%0d addr=%08h data=%08h strb=%h resp=%0d aw_dly=%0d w_dly=%0d b_dly=%0d",
                 g, m_addr[g], m_data[g], m_strb[g], resp, aw_dly, w_dly, b_dly);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        logic [N-1:0] raise;
        for (int i = 0; i < N; i++) rand_payload(i);

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_wstrb", 32'(wstrb), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_resp", 32'(done_resp), 32'd0);
        check("awprot", 32'(awprot), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_awvalid", 32'(awvalid), 32'd0);

        // Round-robin: all pending, each re-raised one cycle after its done
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            run_txn(0, 0, 0, 2'b00, g);
            check("rr_order", 32'(g), 32'(n % N));
            req[g] = 1'b1;
        end
        req = '0;
        @(negedge aclk);

        // Single request
        m_addr[0] = 32'h10; m_data[0] = 32'hDEADBEEF; m_strb[0] = 4'hF;
        req = 4'b0001;
        run_txn(0, 0, 0, 2'b00, g);

        // Split handshakes: AW late, then W late
        req = 4'b0010;
        run_txn(3, 0, 1, 2'b00, g);
        req = 4'b1000;
        run_txn(0, 3, 0, 2'b00, g);

        // Error pass-through
        m_addr[2] = 32'h13;
        req = 4'b0100;
        run_txn(0, 0, 0, 2'b10, g);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            raise = 4'($urandom_range(0, 15)) & ~req;
            if ((req | raise) == '0) raise = 4'b0001 << $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) if (raise[i]) rand_payload(i);
            req = req | raise;
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom_range(0, 3)), g);
        end

        // Mid-transaction reset during RESP, with requester 0 in flight
        req = 4'b0001;
        @(negedge aclk);
        check("mr_awvalid", 32'(awvalid), 32'd1);
        awready = 1'b1;
        wready  = 1'b1;
        @(negedge aclk);
        check("mr_bready", 32'(bready), 32'd1);
        awready = 1'b0;
        wready  = 1'b0;
        aresetn = 1'b0;
        #1;
        check("mr_rst_awvalid", 32'(awvalid), 32'd0);
        check("mr_rst_wvalid", 32'(wvalid), 32'd0);
        check("mr_rst_bready", 32'(bready), 32'd0);
        check("mr_rst_awaddr", awaddr, 32'd0);
        check("mr_rst_wdata", wdata, 32'd0);
        check("mr_rst_wstrb", 32'(wstrb), 32'd0);
        check("mr_rst_done", 32'(done), 32'd0);
        check("mr_rst_done_resp", 32'(done_resp), 32'd0);
        m_last = N - 1;
        req = 4'b0011;
        @(negedge aclk);
        check("mr_no_done", 32'(done), 32'd0);
        aresetn = 1'b1;
        run_txn(0, 0, 0, 2'b00, g);
        check("mr_first_grant", 32'(g), 32'd0);
        run_txn(1, 1, 0, 2'b00, g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4lite_write_arbiter.md
# axi4lite_write_arbiter

Round-robin arbiter sharing one AXI4-Lite write master port among N local requesters. Each requester posts a single 32-bit write (addr/data/strb) on a simple req/done interface. The arbiter serialises the writes onto the AW/W/B channels toward an AXI4-Lite write slave and returns the slave's BRESP to the requester that issued the write. It sits between CPU-side or DMA-side write sources and the peripheral write slave.

## Interface
- N, 4, number of requesters (2..8)
- AWPROT_VAL, 3'b000, constant driven on awprot
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req  in  N  per-requester write request; held high until matching done pulse
- req_addr  in  N*32  requester i address at bits [32i+31:32i]
- req_data  in  N*32  requester i write data, same packing
- req_strb  in  N*4  requester i byte strobes at bits [4i+3:4i]
- done  out  N  one-cycle pulse on bit g when requester g's write completes
- done_resp  out  2  BRESP of the completed write; valid while done != 0
- awvalid  out  1  AXI write address valid
- awready  in  1  AXI write address ready
- awaddr  out  32  AXI write address
- awprot  out  3  tied to AWPROT_VAL
- wvalid  out  1  AXI write data valid
- wready  in  1  AXI write data ready
- wdata  out  32  AXI write data
- wstrb  out  4  AXI write strobes
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response ready
- bresp  in  2  AXI write response

## Operation
- States: IDLE, XFER, RESP, DONE.
- IDLE: if any req bit is set, pick grant g by round-robin: search starts at last+1 (mod N) and takes the first set bit. Latch req_addr/req_data/req_strb of g into awaddr/wdata/wstrb. Set awvalid=1, wvalid=1, last=g, and go to XFER. If req is all zero, stay in IDLE.
- XFER: awvalid clears on the cycle after awvalid&awready. wvalid clears on the cycle after wvalid&wready. The two handshakes are independent and may occur in the same cycle or in either order. When both have completed, go to RESP with bready=1.
- RESP: hold bready=1 until bvalid&bready. On that handshake, register done[g]=1 and done_resp=bresp, clear bready, and go to DONE.
- DONE: done is high for exactly this cycle. Next state is IDLE with done cleared. The DONE cycle lets requester g drop req before IDLE samples it again.
- Request lines are sampled only in IDLE. Changes to req, req_addr, req_data or req_strb in any other state are ignored. Latched outputs stay stable while valid is high.
- SLVERR and any other bresp value are passed through unmodified. The arbiter does not retry.
- Reset values: state=IDLE, last=N-1 (requester 0 has first priority), awvalid=wvalid=bready=0, awaddr=wdata=0, wstrb=0, done=0, done_resp=2'b00.
- Reset mid-transaction: all outputs return to reset values immediately. The in-flight write is abandoned and no done is issued.

## Timing
- req high in IDLE at cycle 0 -> awvalid/wvalid high in cycle 1.
- With awready=wready=1: both handshakes in cycle 1, bready high in cycle 2.
- bvalid in cycle k (k≥2) -> done in cycle k+1 -> IDLE in cycle k+2. The next grant can be issued at the edge ending cycle k+2.
- Minimum spacing between two grants is 4 cycles (IDLE, XFER, RESP, DONE) with zero slave latency.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package axi4lite_pkg holds:
  - OKAY=2'b00 and SLVERR=2'b10;
  - the state encoding localparams for IDLE/XFER/RESP/DONE.
- Sub-module rr_arbiter (parameter N): combinational grant = first set bit of req at or after last+1 mod N, plus a one-hot/index output. It is reusable by a future read-side arbiter.
- The top level holds the FSM, the payload latches and the last pointer.

## Test plan
- Single request: req=4'b0001, addr=0x10, data=0xDEADBEEF, strb=4'hF, slave always ready, bvalid one cycle after handshake, bresp=OKAY.
  - Expect awaddr=0x10 and wdata=0xDEADBEEF in cycle 1, then done=4'b0001 with done_resp=00.
- Round-robin order: all four req high continuously, each re-raised one cycle after its done.
  - Expect grant order 0,1,2,3,0 and awaddr matching each requester's address in turn.
- Split handshakes: awready delayed 3 cycles, wready immediate; then the reverse.
  - Expect wvalid to drop one cycle after the W handshake, awvalid to stay high until the AW handshake, and bready to rise only after both.
- Error pass-through: req[2] with addr=0x13 and slave returns bresp=SLVERR.
  - Expect done=4'b0100 and done_resp=2'b10, then return to IDLE.
- Mid-transaction reset: assert aresetn=0 during RESP.
  - Expect all outputs at reset values. After release, the first grant goes to requester 0 even if requester 1 is also pending.
